intmul_iter_tiled: RTL

Parametrised, iterative DSP-tiled unsigned integer multiplier. It computes C = A × B for arbitrary LOGA × LOGB operand widths and time-multiplexes MUL_PER_CYC DSP-sized partial-product lanes over several cycles. Valid/ready handshakes on input and output let the modular-multiplier datapaths trade DSP count against throughput. It is the area-scalable successor to the fixed 60×60 fully-parallel tiled multiplier and sits in the same slot ahead of the reduction stage.

---
 rtl/intmul_iter_tiled.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/intmul_iter_tiled.sv
// Iterative DSP-tiled unsigned multiplier: C = A * B, issuing MUL_PER_CYC limb
// products per cycle into a shifted accumulator, with valid/ready handshakes.
module intmul_iter_tiled #(
    parameter int unsigned LOGA        = 60,
    parameter int unsigned LOGB        = 60,
    parameter int unsigned WA          = 26,
    parameter int unsigned WB          = 17,
    parameter int unsigned MUL_PER_CYC = 4,
    parameter int unsigned FF_MUL      = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LOGA-1:0]        A,
    input  logic [LOGB-1:0]        B,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LOGA+LOGB-1:0]   C
);

    localparam int unsigned NA   = (LOGA + WA - 1) / WA;
    localparam int unsigned NB   = (LOGB + WB - 1) / WB;
    localparam int unsigned NP   = NA * NB;
    localparam int unsigned ITER = (NP + MUL_PER_CYC - 1) / MUL_PER_CYC;
    localparam int unsigned AW   = NA * WA;
    localparam int unsigned BW   = NB * WB;
    localparam int unsigned PW   = LOGA + LOGB;
    localparam int unsigned PRW  = WA + WB;
    localparam int unsigned XW   = AW + BW;
    localparam int unsigned CW   = (ITER > 1) ? $clog2(ITER) : 1;

    if (MUL_PER_CYC < 1 || MUL_PER_CYC > NP) begin : g_bad_lanes
        $error("intmul_iter_tiled: MUL_PER_CYC must lie in 1..NA*NB");
    end

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                 state, state_nxt;
    logic                   rst_hold;
    logic                   accept;
    logic [CW-1:0]          cnt;
    logic [AW-1:0]          a_reg;
    logic [BW-1:0]          b_reg;
    logic [PW-1:0]          acc;
    logic [PW-1:0]          lane_sum;
    logic                   acc_en;
    logic                   vld_p0;

    logic [MUL_PER_CYC-1:0][PRW-1:0] prod_p0;
    logic [MUL_PER_CYC-1:0][31:0]    sh_p0;
    logic [MUL_PER_CYC-1:0][PRW-1:0] prod_sel;
    logic [MUL_PER_CYC-1:0][31:0]    sh_sel;

    assign accept = in_valid & in_ready;
    assign vld_p0 = (state == RUN);

    // FSM: state register
    always_ff @(posedge clk) begin
        rst_hold <= rst;
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM: next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (cnt == CW'(ITER - 1)) state_nxt = (FF_MUL != 0) ? DRAIN : DONE;
            DRAIN:   state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs; in_ready stays low for the cycle following any reset edge
    always_comb begin
        in_ready  = (state == IDLE) && !rst_hold;
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst)         cnt <= '0;
        else if (accept) cnt <= '0;
        else if (vld_p0) cnt <= cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            a_reg <= AW'(A);
            b_reg <= BW'(B);
        end
    end

    // Stage p0: lane k = cnt*MUL_PER_CYC + lane maps to limb pair (k/NB, k%NB)
    for (genvar l = 0; l < MUL_PER_CYC; l++) begin : g_lane
        logic [31:0]     k, li, lj;
        logic [WA-1:0]   a_limb;
        logic [WB-1:0]   b_limb;
        assign k      = 32'(cnt) * MUL_PER_CYC + l;
        assign li     = k / NB;
        assign lj     = k % NB;
        assign a_limb = WA'(a_reg >> (li * WA));
        assign b_limb = WB'(b_reg >> (lj * WB));
        assign prod_p0[l] = (k < NP) ? PRW'(a_limb) * PRW'(b_limb) : '0;
        assign sh_p0[l]   = li * WA + lj * WB;
    end

    // Stage p1: optional product register in front of the lane adder
    if (FF_MUL != 0) begin : g_ff
        logic [MUL_PER_CYC-1:0][PRW-1:0] prod_p1;
        logic [MUL_PER_CYC-1:0][31:0]    sh_p1;
        logic                            vld_p1;
        always_ff @(posedge clk) begin
            if (rst) begin
                prod_p1 <= '0;
                sh_p1   <= '0;
                vld_p1  <= 1'b0;
            end else begin
                prod_p1 <= prod_p0;
                sh_p1   <= sh_p0;
                vld_p1  <= vld_p0;
            end
        end
        assign prod_sel = prod_p1;
        assign sh_sel   = sh_p1;
        assign acc_en   = vld_p1;
    end else begin : g_comb
        assign prod_sel = prod_p0;
        assign sh_sel   = sh_p0;
        assign acc_en   = vld_p0;
    end

    // Truncation to PW is lossless: every partial sum is bounded by A*B
    always_comb begin
        lane_sum = '0;
        for (int l = 0; l < MUL_PER_CYC; l++) begin
            lane_sum = lane_sum + PW'(XW'(prod_sel[l]) << sh_sel[l]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)         acc <= '0;
        else if (accept) acc <= '0;
        else if (acc_en) acc <= acc + lane_sum;
    end

    assign C = acc;

endmodule
